// File: rtl/s1_pontuacao_pkg.sv
// ----------------------------------------------------------------------------
// s1_pontuacao_pkg
// Shared definitions for the scoring datapath:
//   - default widths and scoring constants (used as parameter defaults)
//   - converter state encoding
//   - ajusta_bcd: the "add 3 to any digit >= 5" step of shift-add-3
// ----------------------------------------------------------------------------
package s1_pontuacao_pkg;

    localparam int PONTOS_WIDTH_PADRAO    = 10;
    localparam int ERRO_WIDTH_PADRAO      = 4;
    localparam int PONTOS_INICIAIS_PADRAO = 100;
    localparam int PENALIDADE_PADRAO      = 10;
    localparam int BONUS_PADRAO           = 5;
    localparam int MAX_PONTOS_PADRAO      = 999;

    // Three BCD digits: centena, dezena, unidade.
    localparam int BCD_WIDTH = 12;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CARREGA = 2'd1,
        DESLOCA = 2'd2,
        FIM     = 2'd3
    } estado_t;

    function automatic logic [BCD_WIDTH-1:0] ajusta_bcd(input logic [BCD_WIDTH-1:0] bcd);
        logic [BCD_WIDTH-1:0] r;
        r = bcd;
        for (int i = 0; i < BCD_WIDTH / 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/s1_pontuacao_if.sv
// ----------------------------------------------------------------------------
// s1_pontuacao_if
// Strobes from the game control FSM into the scoring datapath, plus the
// datapath's status/display outputs.
//   master : control side (drives strobes, reads score/digits)
//   slave  : scoring datapath
// Signals:
//   zeraErro, contaErro, zeraPontos, regPontos, mostraPontos  (master -> slave)
//   db_erros, pontos, centena, dezena, unidade,
//   bcd_valido, exibe_pontos                                  (slave -> master)
// ----------------------------------------------------------------------------
interface s1_pontuacao_if
    import s1_pontuacao_pkg::*;
#(
    parameter int PONTOS_WIDTH = PONTOS_WIDTH_PADRAO,
    parameter int ERRO_WIDTH   = ERRO_WIDTH_PADRAO
);
    logic                    zeraErro;
    logic                    contaErro;
    logic                    zeraPontos;
    logic                    regPontos;
    logic                    mostraPontos;
    logic [ERRO_WIDTH-1:0]   db_erros;
    logic [PONTOS_WIDTH-1:0] pontos;
    logic [3:0]              centena;
    logic [3:0]              dezena;
    logic [3:0]              unidade;
    logic                    bcd_valido;
    logic                    exibe_pontos;

    modport master (
        output zeraErro, contaErro, zeraPontos, regPontos, mostraPontos,
        input  db_erros, pontos, centena, dezena, unidade, bcd_valido, exibe_pontos
    );

    modport slave (
        input  zeraErro, contaErro, zeraPontos, regPontos, mostraPontos,
        output db_erros, pontos, centena, dezena, unidade, bcd_valido, exibe_pontos
    );
endinterface

// File: rtl/s1_bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// s1_bin2bcd_seq
// Iterative binary -> 3-digit BCD converter (shift-add-3, one bit per cycle).
// Ports:
//   clock, reset      clock / asynchronous active-high reset
//   iniciar           request a conversion (sampled only in OCIOSO)
//   valor             binary value, snapshotted in CARREGA
//   ocupado           high from CARREGA through FIM
//   pronto            one-cycle pulse after the digits are written
//   centena/dezena/unidade  BCD digits; hold old value until FIM
// ----------------------------------------------------------------------------
module s1_bin2bcd_seq
    import s1_pontuacao_pkg::*;
#(
    parameter int LARGURA = PONTOS_WIDTH_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [LARGURA-1:0] valor,
    output logic               ocupado,
    output logic               pronto,
    output logic [3:0]         centena,
    output logic [3:0]         dezena,
    output logic [3:0]         unidade
);
    localparam int PASSO_W = $clog2(LARGURA);

    estado_t              estado;
    logic [LARGURA-1:0]   desloc;
    logic [BCD_WIDTH-1:0] bcd;
    logic [PASSO_W-1:0]   passo;

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples the values from before the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= OCIOSO;
            desloc  <= '0;
            bcd     <= '0;
            passo   <= '0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
            centena <= '0;
            dezena  <= '0;
            unidade <= '0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        estado  <= CARREGA;
                        ocupado <= 1'b1;
                    end
                end
                CARREGA: begin
                    desloc <= valor;
                    bcd    <= '0;
                    passo  <= '0;
                    estado <= DESLOCA;
                end
                DESLOCA: begin
                    // Adjust, then shift the next binary bit into the BCD units.
                    {bcd, desloc} <= {ajusta_bcd(bcd), desloc} << 1;
                    passo         <= passo + PASSO_W'(1);
                    if (passo == PASSO_W'(LARGURA - 1)) begin
                        estado <= FIM;
                    end
                end
                FIM: begin
                    centena <= bcd[11:8];
                    dezena  <= bcd[7:4];
                    unidade <= bcd[3:0];
                    ocupado <= 1'b0;
                    pronto  <= 1'b1;
                    estado  <= OCIOSO;
                end
                default: begin
                    estado  <= OCIOSO;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/s1_pontuacao.sv
// ----------------------------------------------------------------------------
// s1_pontuacao
// Scoring datapath for the game: counts wrong plays per round, keeps the
// running score (one update per round) and drives a 3-digit BCD display
// through the iterative converter s1_bin2bcd_seq.
// Ports:
//   clock, reset   clock / asynchronous active-high reset
//   bus (slave)    control strobes in; error count, score, BCD digits,
//                  bcd_valido and exibe_pontos out
// ----------------------------------------------------------------------------
module s1_pontuacao
    import s1_pontuacao_pkg::*;
#(
    parameter int PONTOS_WIDTH    = PONTOS_WIDTH_PADRAO,
    parameter int ERRO_WIDTH      = ERRO_WIDTH_PADRAO,
    parameter int PONTOS_INICIAIS = PONTOS_INICIAIS_PADRAO,
    parameter int PENALIDADE      = PENALIDADE_PADRAO,
    parameter int BONUS           = BONUS_PADRAO,
    parameter int MAX_PONTOS      = MAX_PONTOS_PADRAO
) (
    input  logic         clock,
    input  logic         reset,
    s1_pontuacao_if.slave bus
);
    localparam int PEN_W  = ERRO_WIDTH + PONTOS_WIDTH;
    localparam int SOMA_W = PONTOS_WIDTH + 1;

    logic [ERRO_WIDTH-1:0]   erros;
    logic [PONTOS_WIDTH-1:0] pontos;
    logic [PONTOS_WIDTH-1:0] ultimo;
    logic [PONTOS_WIDTH-1:0] proximo;
    logic [PEN_W-1:0]        pen;
    logic [SOMA_W-1:0]       soma;
    logic                    ocupado;
    logic                    pronto;
    logic                    armado;
    logic                    carrega;

    // Round result. Penalty is formed wide enough that erros*PENALIDADE
    // cannot overflow before it is compared against the score.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        proximo = pontos;
        pen     = PEN_W'(erros) * PEN_W'(PENALIDADE);
        soma    = SOMA_W'(pontos) + SOMA_W'(BONUS);
        if (erros == '0) begin
            proximo = (soma > SOMA_W'(MAX_PONTOS)) ? PONTOS_WIDTH'(MAX_PONTOS)
                                                   : soma[PONTOS_WIDTH-1:0];
        end else begin
            proximo = (pen >= PEN_W'(pontos)) ? '0
                                              : pontos - pen[PONTOS_WIDTH-1:0];
        end
    end

    // The converter's first busy cycle is CARREGA; armado marks that the
    // next busy cycle is a fresh one, so ultimo is captured in the same
    // cycle the converter snapshots its input.
    assign carrega = ocupado & armado;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            erros  <= '0;
            pontos <= PONTOS_WIDTH'(PONTOS_INICIAIS);
            ultimo <= '0;
            armado <= 1'b1;
        end else begin
            if (bus.zeraErro) begin
                erros <= '0;
            end else if (bus.contaErro && (erros != '1)) begin
                erros <= erros + ERRO_WIDTH'(1);
            end

            if (bus.zeraPontos) begin
                pontos <= PONTOS_WIDTH'(PONTOS_INICIAIS);
            end else if (bus.regPontos) begin
                pontos <= proximo;
            end

            if (carrega) begin
                ultimo <= pontos;
                armado <= 1'b0;
            end else if (pronto) begin
                armado <= 1'b1;
            end
        end
    end

    s1_bin2bcd_seq #(
        .LARGURA (PONTOS_WIDTH)
    ) u_bin2bcd (
        .clock   (clock),
        .reset   (reset),
        .iniciar (pontos != ultimo),
        .valor   (pontos),
        .ocupado (ocupado),
        .pronto  (pronto),
        .centena (bus.centena),
        .dezena  (bus.dezena),
        .unidade (bus.unidade)
    );

    assign bus.db_erros     = erros;
    assign bus.pontos       = pontos;
    assign bus.bcd_valido   = !ocupado && (pontos == ultimo);
    assign bus.exibe_pontos = bus.mostraPontos & bus.bcd_valido;
endmodule

// File: tb/tb_s1_pontuacao.sv
// ----------------------------------------------------------------------------
// tb_s1_pontuacao
// Directed bench for s1_pontuacao: reset state, error counting/saturation,
// score bonus/penalty with both clamps, strobe priorities, converter latency,
// held zeraPontos, and reset in the middle of a conversion.
// ----------------------------------------------------------------------------
module tb_s1_pontuacao;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    s1_pontuacao_if bus ();

    s1_pontuacao dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input string nome);
        int n = 0;
        while (!bus.bcd_valido && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (bus.bcd_valido !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: bcd_valido still %b after %0d cycles, need 1", nome, bus.bcd_valido, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.zeraErro = 0; bus.contaErro = 0; bus.zeraPontos = 0;
        bus.regPontos = 0; bus.mostraPontos = 0;
        repeat (3) tick();
        checks++;
        if (bus.pontos !== 10'd100) begin errors++; $display("FAIL reset_pontos: got %0d need 100", bus.pontos); end
        checks++;
        if (bus.db_erros !== 4'd0) begin errors++; $display("FAIL reset_erros: got %0d need 0", bus.db_erros); end
        checks++;
        if ({bus.centena, bus.dezena, bus.unidade} !== 12'h000) begin
            errors++; $display("FAIL reset_digits: got %h%h%h need 000", bus.centena, bus.dezena, bus.unidade);
        end
        checks++;
        if (bus.bcd_valido !== 1'b0) begin errors++; $display("FAIL reset_valido: got %b need 0", bus.bcd_valido); end
        reset = 1'b0;
        repeat (12) tick();
        checks++;
        if (bus.bcd_valido !== 1'b0) begin errors++; $display("FAIL reset_latency_early: bcd_valido %b at cycle 12, need 0", bus.bcd_valido); end
        tick();
        checks++;
        if (bus.bcd_valido !== 1'b1) begin errors++; $display("FAIL reset_latency: bcd_valido %b at cycle 13, need 1", bus.bcd_valido); end
        checks++;
        if ({bus.centena, bus.dezena, bus.unidade} !== 12'h100) begin
            errors++; $display("FAIL reset_conv: got %h%h%h need 100", bus.centena, bus.dezena, bus.unidade);
        end
        #1;
        checks++;
        if (bus.exibe_pontos !== 1'b0) begin errors++; $display("FAIL exibe_off: got %b need 0", bus.exibe_pontos); end
        bus.mostraPontos = 1'b1;
        #1;
        checks++;
        if (bus.exibe_pontos !== 1'b1) begin errors++; $display("FAIL exibe_on: got %b need 1", bus.exibe_pontos); end
        bus.mostraPontos = 1'b0;
    endtask

    task automatic test_penalidade();
        bus.zeraErro = 1; tick(); bus.zeraErro = 0;
        bus.contaErro = 1; repeat (3) tick(); bus.contaErro = 0;
        checks++;
        if (bus.db_erros !== 4'd3) begin errors++; $display("FAIL pen_erros: got %0d need 3", bus.db_erros); end
        bus.regPontos = 1; tick(); bus.regPontos = 0;
        checks++;
        if (bus.pontos !== 10'd70) begin errors++; $display("FAIL pen_pontos: got %0d need 70", bus.pontos); end
        checks++;
        if (bus.bcd_valido !== 1'b0) begin errors++; $display("FAIL pen_invalid: bcd_valido %b need 0", bus.bcd_valido); end
        repeat (12) tick();
        checks++;
        if ({bus.bcd_valido, bus.centena} !== 5'h01) begin
            errors++; $display("FAIL pen_old_digits: valido %b centena %0d need 0/1", bus.bcd_valido, bus.centena);
        end
        tick();
        checks++;
        if ({bus.bcd_valido, bus.centena, bus.dezena, bus.unidade} !== 13'h1070) begin
            errors++; $display("FAIL pen_conv: valido %b digits %h%h%h need 1/070", bus.bcd_valido, bus.centena, bus.dezena, bus.unidade);
        end
    endtask

    task automatic test_teto();
        bus.zeraErro = 1; bus.zeraPontos = 1; tick(); bus.zeraErro = 0; bus.zeraPontos = 0;
        for (int i = 0; i < 179; i++) begin
            bus.regPontos = 1; tick(); bus.regPontos = 0; tick();
        end
        checks++;
        if (bus.pontos !== 10'd995) begin errors++; $display("FAIL teto_995: got %0d need 995", bus.pontos); end
        bus.regPontos = 1; tick(); bus.regPontos = 0;
        checks++;
        if (bus.pontos !== 10'd999) begin errors++; $display("FAIL teto_clamp: got %0d need 999", bus.pontos); end
        bus.regPontos = 1; tick(); bus.regPontos = 0;
        checks++;
        if (bus.pontos !== 10'd999) begin errors++; $display("FAIL teto_hold: got %0d need 999", bus.pontos); end
        wait_valid("teto");
        checks++;
        if ({bus.centena, bus.dezena, bus.unidade} !== 12'h999) begin
            errors++; $display("FAIL teto_conv: got %h%h%h need 999", bus.centena, bus.dezena, bus.unidade);
        end
    endtask

    task automatic test_sat_erros();
        bus.contaErro = 1; repeat (20) tick(); bus.contaErro = 0;
        checks++;
        if (bus.db_erros !== 4'd15) begin errors++; $display("FAIL sat_erros: got %0d need 15", bus.db_erros); end
        bus.zeraPontos = 1; tick(); bus.zeraPontos = 0;
        bus.regPontos = 1; tick(); bus.regPontos = 0;
        checks++;
        if (bus.pontos !== 10'd0) begin errors++; $display("FAIL sat_zero: got %0d need 0", bus.pontos); end
        wait_valid("sat");
        checks++;
        if ({bus.centena, bus.dezena, bus.unidade} !== 12'h000) begin
            errors++; $display("FAIL sat_conv: got %h%h%h need 000", bus.centena, bus.dezena, bus.unidade);
        end
        bus.zeraErro = 1; bus.contaErro = 1; tick(); bus.zeraErro = 0; bus.contaErro = 0;
        checks++;
        if (bus.db_erros !== 4'd0) begin errors++; $display("FAIL zera_prio: got %0d need 0", bus.db_erros); end
    endtask

    task automatic test_mesmo_ciclo();
        bus.zeraPontos = 1; tick(); bus.zeraPontos = 0;
        bus.contaErro = 1; repeat (9) tick();
        bus.regPontos = 1; tick(); bus.regPontos = 0; bus.contaErro = 0;
        checks++;
        if (bus.pontos !== 10'd10) begin errors++; $display("FAIL conta_reg_pontos: got %0d need 10", bus.pontos); end
        checks++;
        if (bus.db_erros !== 4'd10) begin errors++; $display("FAIL conta_reg_erros: got %0d need 10", bus.db_erros); end
        bus.zeraPontos = 1; tick(); bus.zeraPontos = 0;
        bus.regPontos = 1; tick(); bus.regPontos = 0;
        checks++;
        if (bus.pontos !== 10'd0) begin errors++; $display("FAIL pen_igual: got %0d need 0", bus.pontos); end
    endtask

    task automatic test_zera_pontos();
        int quedas = 0;
        logic prev;
        bus.zeraPontos = 1; bus.zeraErro = 1; tick(); bus.zeraPontos = 0; bus.zeraErro = 0;
        bus.contaErro = 1; repeat (5) tick(); bus.contaErro = 0;
        bus.regPontos = 1; tick(); bus.regPontos = 0;
        wait_valid("zp50");
        checks++;
        if ({bus.pontos, bus.centena, bus.dezena, bus.unidade} !== {10'd50, 12'h050}) begin
            errors++; $display("FAIL zp_50: pontos %0d digits %h%h%h need 50/050", bus.pontos, bus.centena, bus.dezena, bus.unidade);
        end
        bus.zeraErro = 1; tick(); bus.zeraErro = 0;
        bus.contaErro = 1; repeat (2) tick(); bus.contaErro = 0;
        prev = bus.bcd_valido;
        bus.zeraPontos = 1; bus.regPontos = 1; tick(); bus.regPontos = 0;
        checks++;
        if (bus.pontos !== 10'd100) begin errors++; $display("FAIL zp_prio: got %0d need 100", bus.pontos); end
        if (prev && !bus.bcd_valido) quedas++;
        prev = bus.bcd_valido;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (prev && !bus.bcd_valido) quedas++;
            prev = bus.bcd_valido;
        end
        bus.zeraPontos = 0;
        checks++;
        if (quedas !== 1) begin errors++; $display("FAIL zp_held_conversions: got %0d need 1", quedas); end
        checks++;
        if ({bus.bcd_valido, bus.centena, bus.dezena, bus.unidade} !== 13'h1100) begin
            errors++; $display("FAIL zp_conv: valido %b digits %h%h%h need 1/100", bus.bcd_valido, bus.centena, bus.dezena, bus.unidade);
        end
    endtask

    task automatic test_reset_meio();
        bus.zeraErro = 1; tick(); bus.zeraErro = 0;
        bus.contaErro = 1; tick(); bus.contaErro = 0;
        bus.regPontos = 1; tick(); bus.regPontos = 0;
        checks++;
        if (bus.pontos !== 10'd90) begin errors++; $display("FAIL rm_pontos: got %0d need 90", bus.pontos); end
        repeat (5) tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.pontos, bus.db_erros} !== {10'd100, 4'd0}) begin
            errors++; $display("FAIL rm_regs: pontos %0d erros %0d need 100/0", bus.pontos, bus.db_erros);
        end
        checks++;
        if ({bus.bcd_valido, bus.centena, bus.dezena, bus.unidade} !== 13'h0000) begin
            errors++; $display("FAIL rm_digits: valido %b digits %h%h%h need 0/000", bus.bcd_valido, bus.centena, bus.dezena, bus.unidade);
        end
        repeat (2) tick();
        reset = 1'b0;
        repeat (12) tick();
        checks++;
        if (bus.bcd_valido !== 1'b0) begin errors++; $display("FAIL rm_early: bcd_valido %b need 0", bus.bcd_valido); end
        tick();
        checks++;
        if ({bus.bcd_valido, bus.centena, bus.dezena, bus.unidade} !== 13'h1100) begin
            errors++; $display("FAIL rm_restart: valido %b digits %h%h%h need 1/100", bus.bcd_valido, bus.centena, bus.dezena, bus.unidade);
        end
    endtask

    initial begin
        test_reset();
        test_penalidade();
        test_teto();
        test_sat_erros();
        test_mesmo_ciclo();
        test_zera_pontos();
        test_reset_meio();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
